// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS/CTRL bit positions and the transmit state encoding.
// Optional build macro UART_TX_PARITY_EN adds a PARITY state (8E1 frames).
package uart_tx_pkg;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_COUNT_LSB = 4;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_CLR_OVF = 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } tx_state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } tx_state_t;
`endif

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Small synchronous FIFO holding bytes waiting to be serialised.
// A push while full is accepted only when a pop happens in the same cycle.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array has no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/CTRL register window,
// byte FIFO and a serialiser driving an idle-high 8N1 line, LSB first.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1).
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0040,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx
);

  import uart_tx_pkg::*;

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic          sel;
  logic [3:0]    offset;
  logic          wr_txdata;
  logic          wr_ctrl;
  logic          enable;
  logic          overflow;
  logic          busy;
  logic          pop;
  logic          start_ok;
  logic          bit_done;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_dout;
  logic [3:0]    count_nib;
  logic [31:0]   status_word;
  logic          unused_wdata;

  tx_state_t     state, state_next;
  logic [BW-1:0] baud, baud_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    data, data_next;

  assign sel          = (Address[31:4] == BASE_ADDR[31:4]);
  assign offset       = Address[3:0];
  assign wr_txdata    = MemWrite && sel && (offset == OFF_TXDATA);
  assign wr_ctrl      = MemWrite && sel && (offset == OFF_CTRL);
  assign start_ok     = enable && !fifo_empty;
  assign bit_done     = (baud == BAUD_LAST);
  assign count_nib    = 4'(fifo_count);
  assign unused_wdata = ^WriteData[31:8];

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .pop   (pop),
    .din   (WriteData[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Control register and sticky overflow flag; a dropped push sets overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      enable   <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        enable <= WriteData[CTRL_ENABLE];
        if (WriteData[CTRL_CLR_OVF]) overflow <= 1'b0;
      end
      if (wr_txdata && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  // State register plus baud/bit counters and the latched frame byte.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      data    <= '0;
    end else begin
      state   <= state_next;
      baud    <= baud_next;
      bit_idx <= bit_next;
      data    <= data_next;
    end
  end

  // Next-state logic: each frame element lasts exactly CLKS_PER_BIT cycles.
  always_comb begin
    state_next = state;
    baud_next  = bit_done ? '0 : baud + 1'b1;
    bit_next   = bit_idx;
    data_next  = data;
    case (state)
      IDLE: begin
        baud_next = '0;
        if (start_ok) begin
          state_next = START;
          data_next  = fifo_dout;
        end
      end
      START: begin
        if (bit_done) begin
          state_next = DATA;
          bit_next   = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_next = bit_idx + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_done) begin
          if (start_ok) begin
            state_next = START;
            data_next  = fifo_dout;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = '0;
      end
    endcase
  end

  // Outputs: serial line level, busy flag and the FIFO pop at frame launch.
  always_comb begin
    tx   = 1'b1;
    busy = (state != IDLE);
    pop  = start_ok && ((state == IDLE) || ((state == STOP) && bit_done));
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = data[bit_idx];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx = even_parity(data);
`endif
      default: tx = 1'b1;
    endcase
  end

  // Combinational register readback; unselected or idle bus reads zero.
  always_comb begin
    status_word                          = '0;
    status_word[ST_FULL]                 = fifo_full;
    status_word[ST_EMPTY]                = fifo_empty;
    status_word[ST_BUSY]                 = busy;
    status_word[ST_OVERFLOW]             = overflow;
    status_word[ST_COUNT_LSB +: 4]       = count_nib;
    ReadData = '0;
    if (MemRead && sel) begin
      case (offset)
        OFF_STATUS: ReadData = status_word;
        OFF_CTRL:   ReadData = {31'b0, enable};
        default:    ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed testbench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Build with UART_TX_PARITY_EN defined to expect 8E1 frames.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h1001_0040;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        tx;

  int total = 0;
  int bad = 0;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .tx        (tx)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata);
    MemWrite  = 1'b1;
    Address   = addr;
    WriteData = wdata;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
    Address = addr;
    MemRead = 1'b1;
    #1;
    data    = ReadData;
    MemRead = 1'b0;
  endtask

  task automatic watchHigh(input int n, output logic saw_low);
    saw_low = 1'b0;
    repeat (n) begin
      if (tx !== 1'b1) saw_low = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkFrame(input logic [7:0] b, input int first, input string tag);
    logic [NBITS-1:0] bits;
    logic [31:0]      st;
    bits          = '1;
    bits[0]       = 1'b0;
    bits[8:1]     = b;
`ifdef UART_TX_PARITY_EN
    bits[9]       = ^b;
`endif
    for (int c = first; c < FRAME; c++) begin
      checkOutput($sformatf("%s_c%0d", tag, c), {31'b0, tx}, {31'b0, bits[c / CPB]});
      if (c == FRAME - 1) begin
        readReg(BASE + 32'h4, st);
        checkOutput({tag, "_busy_last"}, {31'b0, st[2]}, 32'd1);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        saw_low;

    // Reset state and register window decode
    idleCycles(2);
    reset = 1'b1;
    checkOutput("rst_tx", {31'b0, tx}, 32'd1);
    readReg(BASE + 32'h4, rd);
    checkOutput("rst_status", rd, 32'h0000_0002);
    readReg(BASE + 32'h8, rd);
    checkOutput("rst_ctrl", rd, 32'h0000_0001);
    readReg(BASE + 32'hC, rd);
    checkOutput("rd_off_c", rd, 32'h0);
    readReg(BASE + 32'h14, rd);
    checkOutput("rd_unselected", rd, 32'h0);
    Address = BASE + 32'h4;
    #1;
    checkOutput("rd_memread_low", ReadData, 32'h0);

    // Single byte from idle: start bit on second edge after the store
    applyStimulus(BASE, 32'h55);
    checkOutput("push_tx_high", {31'b0, tx}, 32'd1);
    readReg(BASE + 32'h4, rd);
    checkOutput("push_status", rd, 32'h0000_0010);
    idleCycles(1);
    checkFrame(8'h55, 0, "f55");
    readReg(BASE + 32'h4, rd);
    checkOutput("f55_done_status", rd, 32'h0000_0002);

    // Overflow with transmitter disabled, then drain gap-free
    applyStimulus(BASE + 32'h8, 32'h0);
    for (int i = 1; i <= 6; i++) applyStimulus(BASE, i);
    readReg(BASE + 32'h4, rd);
    checkOutput("ovf_status", rd, 32'h0000_0049);
    checkOutput("ovf_tx_idle", {31'b0, tx}, 32'd1);
    applyStimulus(BASE + 32'h8, 32'h3);
    readReg(BASE + 32'h4, rd);
    checkOutput("ovf_cleared", rd, 32'h0000_0041);
    readReg(BASE + 32'h8, rd);
    checkOutput("ctrl_enabled", rd, 32'h0000_0001);
    applyStimulus(BASE, 32'h05);
    readReg(BASE + 32'h4, rd);
    checkOutput("push_pop_full", rd, 32'h0000_0045);
    for (int i = 1; i <= 5; i++) checkFrame(8'(i), 0, $sformatf("q%0d", i));
    readReg(BASE + 32'h4, rd);
    checkOutput("drain_status", rd, 32'h0000_0002);

    // Reset in the middle of a data bit aborts the frame and flushes the FIFO
    applyStimulus(BASE, 32'hA5);
    applyStimulus(BASE, 32'h3C);
    idleCycles(CPB + 3 * CPB);
    checkOutput("a5_bit3", {31'b0, tx}, 32'd0);
    reset = 1'b0;
    idleCycles(1);
    reset = 1'b1;
    checkOutput("abort_tx", {31'b0, tx}, 32'd1);
    readReg(BASE + 32'h4, rd);
    checkOutput("abort_status", rd, 32'h0000_0002);
    watchHigh(2 * FRAME, saw_low);
    checkOutput("abort_no_frame", {31'b0, saw_low}, 32'd0);

    // Disable mid-frame: current frame completes, queued bytes retained
    applyStimulus(BASE, 32'h11);
    applyStimulus(BASE, 32'h22);
    applyStimulus(BASE, 32'h33);
    applyStimulus(BASE + 32'h8, 32'h0);
    checkFrame(8'h11, 2, "f11");
    watchHigh(2 * FRAME, saw_low);
    checkOutput("dis_stays_high", {31'b0, saw_low}, 32'd0);
    readReg(BASE + 32'h4, rd);
    checkOutput("dis_status", rd, 32'h0000_0020);
    readReg(BASE + 32'h8, rd);
    checkOutput("dis_ctrl", rd, 32'h0);
    applyStimulus(BASE + 32'h8, 32'h1);
    idleCycles(1);
    checkFrame(8'h22, 0, "f22");
    checkFrame(8'h33, 0, "f33");
    readReg(BASE + 32'h4, rd);
    checkOutput("resume_status", rd, 32'h0000_0002);

    // Frame length with or without the parity bit
    applyStimulus(BASE, 32'h07);
    idleCycles(1);
    checkFrame(8'h07, 0, "f07");
    readReg(BASE + 32'h4, rd);
    checkOutput("f07_done_status", rd, 32'h0000_0002);
    checkOutput("f07_tx_idle", {31'b0, tx}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
